// File: rtl/qpg_pkg.sv
// qpg_pkg: shared constants for the programmable quadrant pattern generator.
// Register address map, reset defaults and quadrant index constants.
package qpg_pkg;

    // Register address map seen by the PicoBlaze write port
    localparam logic [3:0] QPG_A_SPLITH_LO = 4'd0;
    localparam logic [3:0] QPG_A_SPLITH_HI = 4'd1;
    localparam logic [3:0] QPG_A_SPLITV_LO = 4'd2;
    localparam logic [3:0] QPG_A_SPLITV_HI = 4'd3;
    localparam logic [3:0] QPG_A_COL0      = 4'd4;
    localparam logic [3:0] QPG_A_COL1      = 4'd5;
    localparam logic [3:0] QPG_A_COL2      = 4'd6;
    localparam logic [3:0] QPG_A_COL3      = 4'd7;
    localparam logic [3:0] QPG_A_CTRL      = 4'd8;
    localparam logic [3:0] QPG_A_BLINK     = 4'd9;

    // Reset defaults, colours given as {B,G,R}
    localparam int         QPG_DEF_SPLIT_H = 304;
    localparam int         QPG_DEF_SPLIT_V = 256;
    localparam logic [7:0] QPG_DEF_COL0    = 8'b100;
    localparam logic [7:0] QPG_DEF_COL1    = 8'b110;
    localparam logic [7:0] QPG_DEF_COL2    = 8'b010;
    localparam logic [7:0] QPG_DEF_COL3    = 8'b011;

    // Quadrant index = {below split_v, right of split_h}
    localparam logic [1:0] QPG_Q0 = 2'd0;
    localparam logic [1:0] QPG_Q1 = 2'd1;
    localparam logic [1:0] QPG_Q2 = 2'd2;
    localparam logic [1:0] QPG_Q3 = 2'd3;

endpackage

// File: rtl/qpg_regfile.sv
// qpg_regfile: shadow and active register banks for quad_pattern_gen.
// Writes land in the shadow bank; a commit arms update_pending and the
// whole shadow bank is copied to the active bank at the next frame boundary.
// Optional feature macro: QPG_BLINK_EN (adds the blink mask register).
module qpg_regfile
    import qpg_pkg::*;
#(
    parameter int H_BITS = 10,
    parameter int V_BITS = 10,
    parameter int RGB_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  boundary,
    output logic                  wr_ack,
    output logic                  update_pending,
    output logic [H_BITS-1:0]     split_h,
    output logic [V_BITS-1:0]     split_v,
    output logic [3:0][RGB_W-1:0] colour
`ifdef QPG_BLINK_EN
    ,
    output logic [3:0]            blink_mask
`endif
);

    logic [H_BITS-1:0]     split_h_sh;
    logic [V_BITS-1:0]     split_v_sh;
    logic [3:0][RGB_W-1:0] colour_sh;
`ifdef QPG_BLINK_EN
    logic [3:0]            blink_mask_sh;
`endif

    logic commit;
    logic transfer;

    assign commit   = wr_en && (wr_addr == QPG_A_CTRL) && wr_data[0];
    assign transfer = boundary && update_pending;

    // Shadow bank: byte writes; hi-byte bits beyond the split width fall off in the cast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_h_sh        <= H_BITS'(QPG_DEF_SPLIT_H);
            split_v_sh        <= V_BITS'(QPG_DEF_SPLIT_V);
            colour_sh[QPG_Q0] <= RGB_W'(QPG_DEF_COL0);
            colour_sh[QPG_Q1] <= RGB_W'(QPG_DEF_COL1);
            colour_sh[QPG_Q2] <= RGB_W'(QPG_DEF_COL2);
            colour_sh[QPG_Q3] <= RGB_W'(QPG_DEF_COL3);
`ifdef QPG_BLINK_EN
            blink_mask_sh     <= 4'd0;
`endif
        end else if (wr_en) begin
            case (wr_addr)
                QPG_A_SPLITH_LO: split_h_sh <= H_BITS'({8'(split_h_sh >> 8), wr_data});
                QPG_A_SPLITH_HI: split_h_sh <= H_BITS'({wr_data, 8'(split_h_sh)});
                QPG_A_SPLITV_LO: split_v_sh <= V_BITS'({8'(split_v_sh >> 8), wr_data});
                QPG_A_SPLITV_HI: split_v_sh <= V_BITS'({wr_data, 8'(split_v_sh)});
                QPG_A_COL0, QPG_A_COL1, QPG_A_COL2, QPG_A_COL3:
                    colour_sh[wr_addr[1:0]] <= wr_data[RGB_W-1:0];
`ifdef QPG_BLINK_EN
                QPG_A_BLINK:     blink_mask_sh <= wr_data[3:0];
`endif
                default: ;
            endcase
        end
    end

    // Active bank: whole-bank copy at a frame boundary while a commit is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_h        <= H_BITS'(QPG_DEF_SPLIT_H);
            split_v        <= V_BITS'(QPG_DEF_SPLIT_V);
            colour[QPG_Q0] <= RGB_W'(QPG_DEF_COL0);
            colour[QPG_Q1] <= RGB_W'(QPG_DEF_COL1);
            colour[QPG_Q2] <= RGB_W'(QPG_DEF_COL2);
            colour[QPG_Q3] <= RGB_W'(QPG_DEF_COL3);
`ifdef QPG_BLINK_EN
            blink_mask     <= 4'd0;
`endif
        end else if (transfer) begin
            split_h        <= split_h_sh;
            split_v        <= split_v_sh;
            colour         <= colour_sh;
`ifdef QPG_BLINK_EN
            blink_mask     <= blink_mask_sh;
`endif
        end
    end

    // Pending flag: a commit wins over the clear, so a commit on the boundary waits a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_pending <= 1'b0;
        end else if (commit) begin
            update_pending <= 1'b1;
        end else if (transfer) begin
            update_pending <= 1'b0;
        end
    end

    // Write acknowledge: every strobe answered one cycle later regardless of address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_en;
        end
    end

endmodule

// File: rtl/quad_pattern_gen.sv
// quad_pattern_gen: programmable 2x2 quadrant colour generator for the VGA path.
// Selects one of four colours from the active split points and registers the
// pixel with one cycle of latency.
// Optional feature macro: QPG_BLINK_EN (frame-counter driven quadrant blinking).
module quad_pattern_gen
    import qpg_pkg::*;
#(
    parameter int H_BITS    = 10,
    parameter int V_BITS    = 10,
    parameter int RGB_W     = 3,
    parameter int V_ACTIVE  = 480,
    parameter int BLINK_DIV = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [H_BITS-1:0] hcount,
    input  logic [V_BITS-1:0] vcount,
    input  logic              video_on,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              update_pending,
    output logic [RGB_W-1:0]  rgb_out
);

    logic                  boundary;
    logic [H_BITS-1:0]     split_h;
    logic [V_BITS-1:0]     split_v;
    logic [3:0][RGB_W-1:0] colour;
    logic [1:0]            quad;
    logic [RGB_W-1:0]      pixel;

    assign boundary = (vcount == V_BITS'(V_ACTIVE)) && (hcount == '0);

`ifdef QPG_BLINK_EN
    logic [3:0]           blink_mask;
    logic [BLINK_DIV:0]   frame_cnt;
    logic                 blink_phase;

    assign blink_phase = frame_cnt[BLINK_DIV];

    // Frame counter advances once per frame boundary; its MSB is the blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

    qpg_regfile #(
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .RGB_W  (RGB_W)
    ) u_regfile (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .boundary       (boundary),
        .wr_ack         (wr_ack),
        .update_pending (update_pending),
        .split_h        (split_h),
        .split_v        (split_v),
        .colour         (colour)
`ifdef QPG_BLINK_EN
        ,
        .blink_mask     (blink_mask)
`endif
    );

    // Quadrant pick: splits belong to the low side, so "beyond" means strictly greater
    always_comb begin
        quad  = {vcount > split_v, hcount > split_h};
        pixel = colour[quad];
`ifdef QPG_BLINK_EN
        if (blink_phase && blink_mask[quad]) begin
            pixel = '0;
        end
`endif
    end

    // Output register: blanked outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= video_on ? pixel : '0;
        end
    end

endmodule

// File: tb/tb_quad_pattern_gen.sv
// tb_quad_pattern_gen: self-checking bench for quad_pattern_gen.
// Directed scenarios plus randomized writes/pixels against a register-level
// reference model of the generator's programming and display rules.
module tb_quad_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       update_pending;
    logic [2:0] rgb_out;

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state (plain integers, spec-level)
    int sh_h, sh_v, act_h, act_v;
    int sh_col[4];
    int act_col[4];
    int sh_mask, act_mask, frames;
    bit pend;

    always #5 clk = ~clk;

    quad_pattern_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hcount         (hcount),
        .vcount         (vcount),
        .video_on       (video_on),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .update_pending (update_pending),
        .rgb_out        (rgb_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        sh_h = 304; sh_v = 256; act_h = 304; act_v = 256;
        sh_col[0] = 4; sh_col[1] = 6; sh_col[2] = 2; sh_col[3] = 3;
        act_col = sh_col;
        sh_mask = 0; act_mask = 0; frames = 0;
        pend = 1'b0;
    endfunction

    function automatic int modelPixel(int h, int v);
        int q;
        int c;
        q = (v > act_v ? 2 : 0) + (h > act_h ? 1 : 0);
        c = act_col[q];
`ifdef QPG_BLINK_EN
        if (((frames >> 5) % 2 == 1) && ((act_mask >> q) % 2 == 1)) c = 0;
`endif
        return c;
    endfunction

    function automatic void modelClock(int h, int v, bit we, int addr, int data);
        bit bnd;
        bnd = (v == 480) && (h == 0);
        if (bnd && pend) begin
            act_h = sh_h; act_v = sh_v; act_col = sh_col; act_mask = sh_mask;
            pend = 1'b0;
        end
        if (bnd) frames++;
        if (we) begin
            case (addr)
                0: sh_h = (sh_h / 256) * 256 + data;
                1: sh_h = (data * 256 + sh_h % 256) % 1024;
                2: sh_v = (sh_v / 256) * 256 + data;
                3: sh_v = (data * 256 + sh_v % 256) % 1024;
                4, 5, 6, 7: sh_col[addr - 4] = data % 8;
                8: if (data % 2 == 1) pend = 1'b1;
`ifdef QPG_BLINK_EN
                9: sh_mask = data % 16;
`endif
                default: ;
            endcase
        end
    endfunction

    // One clock of stimulus driven after a falling edge, checked at the next falling edge
    task automatic applyStimulus(input int h, input int v, input bit von, input bit we, input int addr, input int data);
        int exp_rgb;
        hcount   = h[9:0];
        vcount   = v[9:0];
        video_on = von;
        wr_en    = we;
        wr_addr  = addr[3:0];
        wr_data  = data[7:0];
        exp_rgb  = von ? modelPixel(h, v) : 0;
        modelClock(h, v, we, addr, data);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rgb_out", 32'(rgb_out), exp_rgb);
        checkOutput("wr_ack", 32'(wr_ack), 32'(we));
        checkOutput("update_pending", 32'(update_pending), 32'(pend));
    endtask

    task automatic px(input int h, input int v);
        applyStimulus(h, v, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic writeReg(input int addr, input int data);
        applyStimulus(100, 100, 1'b1, 1'b1, addr, data);
    endtask

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_rgb", 32'(rgb_out), 0);
        checkOutput("reset_pending", 32'(update_pending), 0);
        checkOutput("reset_ack", 32'(wr_ack), 0);
        rst_n = 1'b1;

        // Default quadrants and inclusive split edges
        px(0, 0);     checkOutput("t1_q0", 32'(rgb_out), 32'b100);
        px(305, 0);   checkOutput("t1_q1", 32'(rgb_out), 32'b110);
        px(0, 257);   checkOutput("t1_q2", 32'(rgb_out), 32'b010);
        px(639, 479); checkOutput("t1_q3", 32'(rgb_out), 32'b011);
        px(304, 256); checkOutput("t1_edge_q0", 32'(rgb_out), 32'b100);
        px(305, 256); checkOutput("t1_edge_q1", 32'(rgb_out), 32'b110);

        // Shadow write without commit does not reach the display
        writeReg(4, 7);
        px(0, 0);   checkOutput("t2_nocommit", 32'(rgb_out), 32'b100);
        px(0, 480);
        px(0, 0);   checkOutput("t2_nocommit_frame", 32'(rgb_out), 32'b100);
        writeReg(8, 1);
        checkOutput("t2_pending_set", 32'(update_pending), 1);
        px(0, 0);   checkOutput("t2_before_bnd", 32'(rgb_out), 32'b100);
        px(0, 480);
        checkOutput("t2_pending_clr", 32'(update_pending), 0);
        px(0, 0);   checkOutput("t2_after_bnd", 32'(rgb_out), 32'b111);

        // Commit on the exact boundary cycle waits for the next boundary
        writeReg(4, 2);
        applyStimulus(0, 480, 1'b1, 1'b1, 8, 1);
        checkOutput("t3_pending_kept", 32'(update_pending), 1);
        px(0, 0);   checkOutput("t3_no_transfer", 32'(rgb_out), 32'b111);
        px(5, 100);
        px(0, 480);
        checkOutput("t3_pending_clr", 32'(update_pending), 0);
        px(0, 0);   checkOutput("t3_transfer", 32'(rgb_out), 32'b010);

        // Zero splits: only (0,0) belongs to q0
        writeReg(0, 0); writeReg(1, 0); writeReg(2, 0); writeReg(3, 0); writeReg(8, 1);
        px(0, 480);
        px(0, 0);   checkOutput("t4_origin_q0", 32'(rgb_out), 32'b010);
        px(1, 0);   checkOutput("t4_q1", 32'(rgb_out), 32'b110);
        px(0, 1);   checkOutput("t4_q2", 32'(rgb_out), 32'b010);
        px(1, 1);   checkOutput("t4_q3", 32'(rgb_out), 32'b011);
        applyStimulus(1, 1, 1'b0, 1'b0, 0, 0);
        checkOutput("t4_blank", 32'(rgb_out), 0);

        // Reserved address: acked, no effect
        applyStimulus(200, 200, 1'b1, 1'b1, 12, 255);
        checkOutput("t5_reserved_pending", 32'(update_pending), 0);
        px(200, 200); checkOutput("t5_reserved_nochange", 32'(rgb_out), 32'b011);

        // Mid-frame reset with a pending commit
        writeReg(7, 5); writeReg(8, 1);
        px(200, 200);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_rgb", 32'(rgb_out), 0);
        checkOutput("t5_rst_pending", 32'(update_pending), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        px(0, 0);     checkOutput("t5_def_q0", 32'(rgb_out), 32'b100);
        px(639, 479); checkOutput("t5_def_q3", 32'(rgb_out), 32'b011);
        px(0, 480);
        px(639, 479); checkOutput("t5_def_kept", 32'(rgb_out), 32'b011);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int h, v, addr, data;
            bit von, we;
            if ($urandom_range(0, 15) == 0) begin
                h = 0; v = 480;
            end else begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end
            von  = ($urandom_range(0, 7) != 0);
            we   = ($urandom_range(0, 3) == 0);
            addr = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) addr = 8;
            data = $urandom_range(0, 255);
            applyStimulus(h, v, von, we, addr, data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
